data_mem: RTL and testbench

- Word-organised data memory for the multi-cycle MIPS CPU; sits on the datapath's load/store port.
- Byte address in, 32-bit word in/out.
- Reads are combinational (asynchronous). Writes are synchronous on the rising clock edge when write-enable is high.
- Synchronous reset clears the whole array.

---
 rtl/data_mem_if.sv | 41 ++++
 rtl/data_mem.sv | 54 +++++
 tb/tb_data_mem.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: load/store port between the MIPS datapath and data_mem.
// err_o exists only when DATAMEM_RANGE_CHECK_EN is defined.
interface data_mem_if;
  logic [31:0] addr;
  logic [31:0] data;
  logic        we;
  logic [31:0] data_o;
`ifdef DATAMEM_RANGE_CHECK_EN
  logic        err_o;

  modport master (
    output addr,
    output data,
    output we,
    input  data_o,
    input  err_o
  );

  modport slave (
    input  addr,
    input  data,
    input  we,
    output data_o,
    output err_o
  );
`else
  modport master (
    output addr,
    output data,
    output we,
    input  data_o
  );

  modport slave (
    input  addr,
    input  data,
    input  we,
    output data_o
  );
`endif
endinterface

// File: rtl/data_mem.sv
// data_mem: word-organised data memory, combinational read, synchronous write and clear.
// Define DATAMEM_RANGE_CHECK_EN to reject addresses beyond DEPTH words and drive bus.err_o.
module data_mem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic      clk,
  input  logic      rst,
  data_mem_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("data_mem: DEPTH must be a power of two and at least 4");
  end

  // Zero at power-up so reads are defined before the first reset or write.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [AW-1:0] idx;
  logic          in_range;

  always_comb idx = bus.addr[AW+1:2];

`ifdef DATAMEM_RANGE_CHECK_EN
  logic [1:0] unused_addr_bits;

  always_comb begin
    in_range         = ~|bus.addr[31:AW+2];
    bus.err_o        = ~in_range;
    unused_addr_bits = bus.addr[1:0];
  end
`else
  // Upper bits are dropped so the address space wraps every DEPTH words.
  logic [31-AW:0] unused_addr_bits;

  always_comb begin
    in_range         = 1'b1;
    unused_addr_bits = {bus.addr[31:AW+2], bus.addr[1:0]};
  end
`endif

  always_comb bus.data_o = in_range ? mem[idx] : '0;

  // Reset wins over a same-edge write; no bypass, so data_o shows new data only after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= '0;
      end
    end else if (bus.we && in_range) begin
      mem[idx] <= bus.data;
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed checks of data_mem (DEPTH=256), including the range-check build.
module tb_data_mem;
  logic clk;
  logic rst;
  logic clk_en;
  int   tests_run;
  int   tests_failed;

  data_mem_if bus ();

  data_mem #(.DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic set_addr(input logic [31:0] a);
    bus.addr = a;
    #1;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr = a;
    bus.data = d;
    bus.we   = 1'b1;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
  endtask

  task automatic test_reset;
    set_addr(32'h0);
    tests_run++;
    if (bus.data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL powerup_addr0: got %h, expected %h", bus.data_o, 32'h0);
    end
    #100;
    set_addr(32'h4);
    tests_run++;
    if (bus.data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL powerup_addr4: got %h, expected %h", bus.data_o, 32'h0);
    end
`ifdef DATAMEM_RANGE_CHECK_EN
    tests_run++;
    if (bus.err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL powerup_err: got %b, expected %b", bus.err_o, 1'b0);
    end
`endif
  endtask

  task automatic test_write_read;
    logic [31:0] addrs [3];
    logic [31:0] exps  [3];
    addrs = '{32'h4, 32'h7, 32'h0};
    exps  = '{32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    write_word(32'h4, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      set_addr(addrs[i]);
      tests_run++;
      if (bus.data_o !== exps[i]) begin
        tests_failed++;
        $display("FAIL write_read @%h: got %h, expected %h", addrs[i], bus.data_o, exps[i]);
      end
    end
  endtask

  task automatic test_comb_read;
    write_word(32'h0, 32'h11111111);
    write_word(32'h4, 32'h22222222);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic [31:0] e;
      a = (i % 2 == 0) ? 32'h0 : 32'h4;
      e = (i % 2 == 0) ? 32'h11111111 : 32'h22222222;
      set_addr(a);
      tests_run++;
      if (bus.data_o !== e) begin
        tests_failed++;
        $display("FAIL comb_read @%h step %0d: got %h, expected %h", a, i, bus.data_o, e);
      end
    end
  endtask

  task automatic test_read_during_write;
    write_word(32'h8, 32'hAAAA5555);
    @(negedge clk);
    bus.addr = 32'h8;
    bus.data = 32'h12345678;
    bus.we   = 1'b1;
    #1;
    tests_run++;
    if (bus.data_o !== 32'hAAAA5555) begin
      tests_failed++;
      $display("FAIL rdw_before_edge: got %h, expected %h", bus.data_o, 32'hAAAA5555);
    end
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    tests_run++;
    if (bus.data_o !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL rdw_after_edge: got %h, expected %h", bus.data_o, 32'h12345678);
    end
  endtask

  task automatic test_we_low;
    @(negedge clk);
    bus.addr = 32'h8;
    bus.data = 32'h0BADF00D;
    bus.we   = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.data_o !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL we_low_hold: got %h, expected %h", bus.data_o, 32'h12345678);
    end
  endtask

  task automatic test_reset_priority;
    logic [31:0] addrs [5];
    addrs = '{32'hC, 32'h0, 32'h4, 32'h8, 32'h3FC};
    write_word(32'h3FC, 32'h55AA55AA);
    @(negedge clk);
    rst      = 1'b1;
    bus.we   = 1'b1;
    bus.addr = 32'hC;
    bus.data = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bus.we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_addr(addrs[i]);
      tests_run++;
      if (bus.data_o !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_clear @%h: got %h, expected %h", addrs[i], bus.data_o, 32'h0);
      end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    bus.we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.addr = 32'h3F0 + 32'(i * 4);
      bus.data = 32'hB0B0_0000 + 32'(i);
      @(posedge clk);
      #1;
      if (i < 3) @(negedge clk);
    end
    bus.we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic [31:0] e;
      a = 32'h3F0 + 32'(i * 4);
      e = 32'hB0B0_0000 + 32'(i);
      set_addr(a);
      tests_run++;
      if (bus.data_o !== e) begin
        tests_failed++;
        $display("FAIL back_to_back @%h: got %h, expected %h", a, bus.data_o, e);
      end
    end
  endtask

  task automatic test_wrap_range;
`ifdef DATAMEM_RANGE_CHECK_EN
    set_addr(32'h400);
    tests_run++;
    if (bus.err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL range_err_400: got %b, expected %b", bus.err_o, 1'b1);
    end
    write_word(32'h400, 32'hCAFEF00D);
    set_addr(32'h400);
    tests_run++;
    if (bus.data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL range_read_400: got %h, expected %h", bus.data_o, 32'h0);
    end
    set_addr(32'h0);
    tests_run++;
    if (bus.data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL range_word0_kept: got %h, expected %h", bus.data_o, 32'h0);
    end
    tests_run++;
    if (bus.err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL range_err_0: got %b, expected %b", bus.err_o, 1'b0);
    end
    set_addr(32'h8000_03F0);
    tests_run++;
    if (bus.err_o !== 1'b1 || bus.data_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL range_msb: got err=%b data=%h, expected err=1 data=%h", bus.err_o, bus.data_o, 32'h0);
    end
`else
    write_word(32'h400, 32'hCAFEF00D);
    set_addr(32'h0);
    tests_run++;
    if (bus.data_o !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL wrap_word0: got %h, expected %h", bus.data_o, 32'hCAFEF00D);
    end
    set_addr(32'h8000_03F0);
    tests_run++;
    if (bus.data_o !== 32'hB0B00000) begin
      tests_failed++;
      $display("FAIL wrap_msb_alias: got %h, expected %h", bus.data_o, 32'hB0B00000);
    end
`endif
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    clk_en       = 1'b0;
    rst          = 1'b0;
    bus.we       = 1'b0;
    bus.data     = '0;
    bus.addr     = '0;

    test_reset;
    clk_en = 1'b1;
    test_write_read;
    test_comb_read;
    test_read_during_write;
    test_we_low;
    test_reset_priority;
    test_back_to_back;
    test_wrap_range;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
